pose_integrator: RTL and testbench

//  Dead-reckoning pose integrator: on each sample tick, multiplies body-to-global velocities VX, VY, WZ
//  by fixed timestep constants and accumulates them into POSX/POSY [m] and THETA [deg].

---
 rtl/pose_integrator.sv | 169 ++++++++++++++++
 tb/tb_pose_integrator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pose_integrator.sv
// Dead-reckoning integrator for X/Y position and heading (sign-magnitude fixed point).
// One shift-add multiplier is time-multiplexed over the X, Y and THETA channels.
module pose_integrator #(
  parameter int                 N_WIDTH    = 20,
  parameter int                 Q_WIDTH    = 8,
  parameter logic [N_WIDTH-1:0] DT_LIN     = 20'd11,
  parameter logic [N_WIDTH-1:0] DT_ANG     = 20'd615,
  parameter logic [N_WIDTH-1:0] THETA_INIT = 20'd23040
) (
  input  logic               POS_INTEGRATOR_CLOCK_50,
  input  logic               POS_INTEGRATOR_Reset_InHigh,
  input  logic               POS_INTEGRATOR_SETBEGIN_InLow,
  input  logic               POS_INTEGRATOR_TICK_InLow,
  input  logic [N_WIDTH-1:0] POS_INTEGRATOR_VX_InBus,
  input  logic [N_WIDTH-1:0] POS_INTEGRATOR_VY_InBus,
  input  logic [N_WIDTH-1:0] POS_INTEGRATOR_WZ_InBus,
  output logic [N_WIDTH-1:0] POS_INTEGRATOR_POSX_OutBus,
  output logic [N_WIDTH-1:0] POS_INTEGRATOR_POSY_OutBus,
  output logic [N_WIDTH-1:0] POS_INTEGRATOR_THETA_OutBus,
  output logic               POS_INTEGRATOR_BUSY_Out,
  output logic               POS_INTEGRATOR_DONE_Out,
  output logic               POS_INTEGRATOR_OVF_Out,
  output logic               POS_INTEGRATOR_TICKMISS_Out
);
  localparam int M  = N_WIDTH - 1;
  localparam int PW = 2 * N_WIDTH;
  localparam int CW = $clog2(N_WIDTH);
  localparam logic [M-1:0]       MAG_MAX   = '1;
  localparam logic [N_WIDTH+1:0] FULL_TURN = (N_WIDTH+2)'(360) << Q_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;

  state_t             r_state;
  logic [1:0]         r_ch;
  logic [CW-1:0]      r_cnt;
  logic               r_sx;
  logic [N_WIDTH-1:0] r_vy, r_wz;
  logic [PW-1:0]      r_prod, r_mcand;
  logic [M-1:0]       r_mplier;
  logic [N_WIDTH-1:0] r_posx, r_posy, r_theta;
  logic               r_busy, r_done, r_ovf, r_tickmiss;

  logic                      w_sel_sign;
  logic [PW-1:0]             w_scaled;
  logic                      w_mul_ovf;
  logic [M-1:0]              w_pmag;
  logic                      w_psign;
  logic [N_WIDTH-1:0]        w_acc;
  logic signed [N_WIDTH:0]   w_a, w_b, w_sum;
  logic [N_WIDTH:0]          w_sum_abs;
  logic                      w_sum_ovf;
  logic [N_WIDTH-1:0]        w_pos_next;
  logic signed [N_WIDTH+1:0] w_th_s;
  logic [N_WIDTH-1:0]        w_theta_next;

  always_comb begin
    w_sel_sign = (r_ch == 2'd0) ? r_sx : (r_ch == 2'd1) ? r_vy[M] : r_wz[M];
    w_scaled   = r_prod >> Q_WIDTH;
    w_mul_ovf  = |w_scaled[PW-1:M];
    w_pmag     = w_mul_ovf ? MAG_MAX : w_scaled[M-1:0];
    w_psign    = w_sel_sign & (|w_pmag);

    // Position add is done in two's complement, then folded back to sign-magnitude.
    w_acc = (r_ch == 2'd0) ? r_posx : r_posy;
    w_a   = $signed({2'b00, w_acc[M-1:0]});
    if (w_acc[M]) w_a = -w_a;
    w_b   = $signed({2'b00, w_pmag});
    if (w_psign) w_b = -w_b;
    w_sum     = w_a + w_b;
    w_sum_abs = w_sum[N_WIDTH] ? $unsigned(-w_sum) : $unsigned(w_sum);
    w_sum_ovf = |w_sum_abs[N_WIDTH:M];
    w_pos_next = w_sum_ovf ? {w_sum[N_WIDTH], MAG_MAX}
                           : {w_sum[N_WIDTH] & (|w_sum_abs[M-1:0]), w_sum_abs[M-1:0]};

    w_th_s = $signed({2'b00, r_theta});
    if (w_psign) w_th_s = w_th_s - $signed({3'b000, w_pmag});
    else         w_th_s = w_th_s + $signed({3'b000, w_pmag});
    if (w_th_s[N_WIDTH+1])                 w_th_s = w_th_s + $signed(FULL_TURN);
    else if (w_th_s >= $signed(FULL_TURN)) w_th_s = w_th_s - $signed(FULL_TURN);
    w_theta_next = w_th_s[N_WIDTH-1:0];
  end

  always_ff @(posedge POS_INTEGRATOR_CLOCK_50 or posedge POS_INTEGRATOR_Reset_InHigh) begin
    if (POS_INTEGRATOR_Reset_InHigh) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_cnt      <= '0;
      r_sx       <= 1'b0;
      r_vy       <= '0;
      r_wz       <= '0;
      r_prod     <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_posx     <= '0;
      r_posy     <= '0;
      r_theta    <= THETA_INIT;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_tickmiss <= 1'b0;
    end else if (!POS_INTEGRATOR_SETBEGIN_InLow) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_cnt      <= '0;
      r_posx     <= '0;
      r_posy     <= '0;
      r_theta    <= THETA_INIT;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_tickmiss <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!POS_INTEGRATOR_TICK_InLow && r_state != S_IDLE) r_tickmiss <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!POS_INTEGRATOR_TICK_InLow) begin
            r_sx     <= POS_INTEGRATOR_VX_InBus[M];
            r_vy     <= POS_INTEGRATOR_VY_InBus;
            r_wz     <= POS_INTEGRATOR_WZ_InBus;
            r_mplier <= POS_INTEGRATOR_VX_InBus[M-1:0];
            r_mcand  <= {{N_WIDTH{1'b0}}, DT_LIN};
            r_prod   <= '0;
            r_ch     <= 2'd0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(M - 1)) r_state <= S_ACC;
        end
        S_ACC: begin
          if (w_mul_ovf) r_ovf <= 1'b1;
          if (r_ch == 2'd2) begin
            r_theta <= w_theta_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_sum_ovf) r_ovf <= 1'b1;
            if (r_ch == 2'd0) r_posx <= w_pos_next;
            else              r_posy <= w_pos_next;
            // Preload the multiplier for the next channel.
            r_mplier <= (r_ch == 2'd0) ? r_vy[M-1:0] : r_wz[M-1:0];
            r_mcand  <= (r_ch == 2'd0) ? {{N_WIDTH{1'b0}}, DT_LIN} : {{N_WIDTH{1'b0}}, DT_ANG};
            r_prod   <= '0;
            r_cnt    <= '0;
            r_ch     <= r_ch + 2'd1;
            r_state  <= S_MUL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign POS_INTEGRATOR_POSX_OutBus  = r_posx;
  assign POS_INTEGRATOR_POSY_OutBus  = r_posy;
  assign POS_INTEGRATOR_THETA_OutBus = r_theta;
  assign POS_INTEGRATOR_BUSY_Out     = r_busy;
  assign POS_INTEGRATOR_DONE_Out     = r_done;
  assign POS_INTEGRATOR_OVF_Out      = r_ovf;
  assign POS_INTEGRATOR_TICKMISS_Out = r_tickmiss;
endmodule

// File: tb/tb_pose_integrator.sv
// Self-checking bench for pose_integrator: directed scenarios plus randomized updates
// compared against an integer-arithmetic pose model.
module tb_pose_integrator;
  localparam int N    = 20;
  localparam int FULL = 92160;
  localparam int MAXM = 524287;

  logic clk = 1'b0, rst = 1'b1, setb_n = 1'b1, tick_n = 1'b1;
  logic [N-1:0] vx = '0, vy = '0, wz = '0;
  logic [N-1:0] posx, posy, theta;
  logic busy, done, ovf, tickmiss;

  int n_checks = 0;
  int n_errors = 0;
  int m_x, m_y, m_th;
  bit m_ovf, m_miss;

  pose_integrator dut (
    .POS_INTEGRATOR_CLOCK_50      (clk),
    .POS_INTEGRATOR_Reset_InHigh  (rst),
    .POS_INTEGRATOR_SETBEGIN_InLow(setb_n),
    .POS_INTEGRATOR_TICK_InLow    (tick_n),
    .POS_INTEGRATOR_VX_InBus      (vx),
    .POS_INTEGRATOR_VY_InBus      (vy),
    .POS_INTEGRATOR_WZ_InBus      (wz),
    .POS_INTEGRATOR_POSX_OutBus   (posx),
    .POS_INTEGRATOR_POSY_OutBus   (posy),
    .POS_INTEGRATOR_THETA_OutBus  (theta),
    .POS_INTEGRATOR_BUSY_Out      (busy),
    .POS_INTEGRATOR_DONE_Out      (done),
    .POS_INTEGRATOR_OVF_Out       (ovf),
    .POS_INTEGRATOR_TICKMISS_Out  (tickmiss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [N-1:0] enc(input int x);
    logic [N-1:0] r;
    if (x < 0) r = {1'b1, 19'(-x)};
    else       r = {1'b0, 19'(x)};
    return r;
  endfunction

  // Signed real-valued step: |v|*dt/2^8 truncated, clamped to the 19-bit magnitude range.
  function automatic int scale(input logic [N-1:0] v, input longint dt);
    longint p;
    p = (longint'(v[N-2:0]) * dt) / 256;
    if (p > MAXM) begin
      m_ovf = 1'b1;
      p = MAXM;
    end
    return v[N-1] ? -int'(p) : int'(p);
  endfunction

  function automatic int sat_add(input int a, input int b);
    int s;
    s = a + b;
    if (s > MAXM)       begin s = MAXM;  m_ovf = 1'b1; end
    else if (s < -MAXM) begin s = -MAXM; m_ovf = 1'b1; end
    return s;
  endfunction

  task automatic model_init();
    m_x = 0; m_y = 0; m_th = 23040; m_ovf = 1'b0; m_miss = 1'b0;
  endtask

  task automatic model_update(input logic [N-1:0] ax, input logic [N-1:0] ay, input logic [N-1:0] aw);
    int t;
    m_x = sat_add(m_x, scale(ax, 11));
    m_y = sat_add(m_y, scale(ay, 11));
    t = m_th + scale(aw, 615);
    if (t >= FULL)  t = t - FULL;
    else if (t < 0) t = t + FULL;
    m_th = t;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_posx"},  posx,  enc(m_x));
    chk({tag, "_posy"},  posy,  enc(m_y));
    chk({tag, "_theta"}, theta, enc(m_th));
    chk({tag, "_ovf"},   ovf,   m_ovf);
    chk({tag, "_miss"},  tickmiss, m_miss);
  endtask

  // Called at a negedge; leaves at the negedge after the final (THETA) write.
  // miss_at >= 0 injects an extra tick landing on edge k+miss_at+1.
  task automatic do_update(input logic [N-1:0] ax, input logic [N-1:0] ay,
                           input logic [N-1:0] aw, input int miss_at);
    vx = ax; vy = ay; wz = aw; tick_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tick_n = 1'b0 ^ 1'b1;
    vx = 20'($urandom); vy = 20'($urandom); wz = 20'($urandom);
    model_update(ax, ay, aw);
    if (miss_at >= 0) m_miss = 1'b1;
    chk("busy_start", busy, 1'b1);
    for (int e = 1; e <= 60; e++) begin
      if (e - 1 == miss_at) tick_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tick_n = 1'b1;
      if (e == 59) begin
        chk("done_early", done, 1'b0);
        chk("busy_hold",  busy, 1'b1);
      end
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_end",   busy, 1'b0);
    check_state("upd");
    $display("update vx=%h vy=%h wz=%h miss_at=%0d -> posx=%h posy=%h theta=%0d ovf=%0b miss=%0b",
             ax, ay, aw, miss_at, posx, posy, theta, ovf, tickmiss);
  endtask

  task automatic do_setbegin();
    setb_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    setb_n = 1'b1;
    model_init();
    check_state("setbegin");
    chk("setbegin_busy", busy, 1'b0);
    chk("setbegin_done", done, 1'b0);
    $display("setbegin -> posx=%h posy=%h theta=%0d", posx, posy, theta);
  endtask

  function automatic logic [N-1:0] rnd_lin();
    logic [N-2:0] m;
    if ($urandom_range(0, 1) == 1) m = 19'($urandom_range(0, 4000));
    else                           m = 19'($urandom);
    return {1'($urandom_range(0, 1)), m};
  endfunction

  function automatic logic [N-1:0] rnd_ang();
    return {1'($urandom_range(0, 1)), 19'($urandom_range(0, 38000))};
  endfunction

  initial begin
    int done_seen;
    int busy_seen;
    model_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_state("reset");
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;

    // Constant +1.0 m/s in X, three ticks ~100 cycles apart.
    for (int i = 0; i < 3; i++) begin
      do_update(20'd256, 20'd0, 20'd0, -1);
      chk("t1_posx_const", posx, 20'(11 * (i + 1)));
      repeat (39) @(negedge clk);
    end

    // Negative Y, then zero Y.
    do_setbegin();
    do_update(20'd0, 20'h80200, 20'd0, -1);
    chk("t2_posy_const", posy, 20'h80016);
    do_update(20'd0, 20'd0, 20'd0, -1);

    // Heading increments and wrap in both directions.
    do_setbegin();
    do_update(20'd0, 20'd0, 20'd256, -1);
    chk("t3_theta_small", theta, 20'd23655);
    do_setbegin();
    do_update(20'd0, 20'd0, 20'd25600, -1);
    do_update(20'd0, 20'd0, 20'd25600, -1);
    chk("t3_theta_wrap", theta, 20'd53880);
    do_setbegin();
    do_update(20'd0, 20'd0, {1'b1, 19'd25600}, -1);
    chk("t3_theta_neg", theta, 20'd53700);

    // Saturation of POSX at full-scale velocity.
    do_setbegin();
    for (int i = 0; i < 25; i++) do_update(20'h7FFFF, 20'd0, 20'd0, -1);
    chk("t4_posx_sat", posx, 20'd524287);
    chk("t4_ovf", ovf, 1'b1);

    // Tick while busy is dropped and flagged.
    do_setbegin();
    do_update(20'd256, 20'd0, 20'd0, 4);
    chk("t5_posx_once", posx, 20'd11);
    do_setbegin();

    // Asynchronous reset in the middle of an update.
    do_update(20'd256, 20'd0, 20'd0, -1);
    vx = 20'd256; tick_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tick_n = 1'b1;
    model_update(20'd256, 20'd0, 20'd0);
    repeat (29) @(negedge clk);
    chk("t6_posx_mid", posx, enc(m_x));
    rst = 1'b1;
    #1;
    model_init();
    chk("t6_posx_rst", posx, 20'd0);
    chk("t6_busy_rst", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("t6_no_done", done_seen, 0);
    check_state("t6_after_rst");

    // SETBEGIN and tick on the same edge: tick is dropped silently.
    do_update(20'd256, 20'd0, 20'd0, -1);
    setb_n = 1'b0; tick_n = 1'b0; vx = 20'd256;
    @(posedge clk);
    @(negedge clk);
    setb_n = 1'b1; tick_n = 1'b1;
    model_init();
    busy_seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (busy || done) busy_seen++;
    end
    chk("t6_sb_tick_idle", busy_seen, 0);
    check_state("t6_sb_tick");

    // Randomized updates with random idle gaps and occasional ticks while busy.
    do_setbegin();
    for (int i = 0; i < 40; i++) begin
      int gap;
      int miss;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      miss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 59)) : -1;
      do_update(rnd_lin(), rnd_lin(), rnd_ang(), miss);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
